bus_dma_master: RTL and testbench

//  Word-copy DMA engine; a bus initiator on the valid/ready memory bus (the same bus the CPU drives).
//  The CPU programs it through a ctrl_* register port with the same signalling as the UART register port.

---
 rtl/bus_dma_master.sv | 162 ++++++++++++++++
 tb/tb_bus_dma_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: the CPU programs SRC/DST/LEN/CTRL over the register port,
// then the engine alternates one bus read and one bus write per word.
module bus_dma_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ctrl_wr,
  input  logic              ctrl_rd,
  input  logic [31:0]       ctrl_addr,
  input  logic [31:0]       ctrl_wdat,
  output logic [31:0]       ctrl_rdat,
  output logic              ctrl_done,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              irq
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_GAP_W = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_GAP_R = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [31:0]       buffer;
  logic              done;
  logic              ie;
  logic              abort_pend;

  logic              busy;
  logic [1:0]        reg_sel;
  logic              wr_ack;
  logic              wr_src;
  logic              wr_dst;
  logic              wr_len;
  logic              wr_ctrl;
  logic              start_req;
  logic              abort_req;
  logic              clr_req;
  logic              rd_done;
  logic              wr_done;
  logic              finish;
  logic              done_set;
  logic [31:0]       rd_mux;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{ctrl_addr[31:4], ctrl_addr[1:0]};

  assign busy    = (state != ST_IDLE);
  assign reg_sel = ctrl_addr[3:2];

  // Register side effects land at the end of the acknowledge cycle.
  assign wr_ack    = ctrl_wr & ctrl_done;
  assign wr_src    = wr_ack & (reg_sel == 2'd0) & ~busy;
  assign wr_dst    = wr_ack & (reg_sel == 2'd1) & ~busy;
  assign wr_len    = wr_ack & (reg_sel == 2'd2) & ~busy;
  assign wr_ctrl   = wr_ack & (reg_sel == 2'd3);
  assign start_req = wr_ctrl & ctrl_wdat[0] & ~ctrl_wdat[1] & ~busy;
  assign abort_req = wr_ctrl & ctrl_wdat[1] & busy;
  assign clr_req   = wr_ctrl & ctrl_wdat[3];

  assign rd_done  = (state == ST_RD) & mem_ready;
  assign wr_done  = (state == ST_WR) & mem_ready;
  assign finish   = ((state == ST_GAP_W) & abort_pend) |
                    ((state == ST_GAP_R) & (abort_pend | (len == '0)));
  assign done_set = finish | (start_req & (len == '0));

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux = 32'(src);
      2'd1:    rd_mux = 32'(dst);
      2'd2:    rd_mux = 32'(len);
      default: rd_mux = {29'd0, ie, done, busy};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= (ctrl_wr | ctrl_rd) & ~ctrl_done;
      ctrl_rdat <= (ctrl_rd & ~ctrl_done) ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_req && (len != '0)) state <= ST_RD;
        ST_RD:    if (mem_ready) state <= ST_GAP_W;
        ST_GAP_W: state <= abort_pend ? ST_IDLE : ST_WR;
        ST_WR:    if (mem_ready) state <= ST_GAP_R;
        ST_GAP_R: state <= (abort_pend || (len == '0)) ? ST_IDLE : ST_RD;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      buffer <= '0;
    end else begin
      if (wr_src)
        src <= {ctrl_wdat[ADDR_W-1:2], 2'b00};
      else if (wr_done)
        src <= src + ADDR_W'(4);
      if (wr_dst)
        dst <= {ctrl_wdat[ADDR_W-1:2], 2'b00};
      else if (wr_done)
        dst <= dst + ADDR_W'(4);
      if (wr_len)
        len <= ctrl_wdat[LEN_W-1:0];
      else if (wr_done)
        len <= len - LEN_W'(1);
      if (rd_done)
        buffer <= mem_rdata;
    end
  end

  // A same-cycle DONE set beats the write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done       <= 1'b0;
      ie         <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (done_set)
        done <= 1'b1;
      else if (clr_req)
        done <= 1'b0;
      if (wr_ctrl)
        ie <= ctrl_wdat[2];
      if (finish)
        abort_pend <= 1'b0;
      else if (abort_req)
        abort_pend <= 1'b1;
    end
  end

  assign mem_valid = (state == ST_RD) | (state == ST_WR);
  assign mem_addr  = (state == ST_WR) ? dst : ((state == ST_RD) ? src : '0);
  assign mem_wdata = (state == ST_WR) ? buffer : '0;
  assign mem_wstrb = (state == ST_WR) ? 4'hF : 4'h0;
  assign irq       = done & ie;

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a behavioural memory slave of programmable latency.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ctrl_wr, ctrl_rd;
  logic [31:0] ctrl_addr, ctrl_wdat, ctrl_rdat;
  logic        ctrl_done;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  int fixed_dly = 0;
  int stab_err  = 0;
  int gap_err   = 0;
  int valid_cnt = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  bus_dma_master #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory slave: acks each request after fixed_dly cycles (random 0..7 when negative).
  initial begin : slave
    bit          pend;
    int          dly;
    logic [31:0] a0, w0;
    logic [3:0]  s0;
    pend = 0; dly = 0; a0 = '0; w0 = '0; s0 = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) valid_cnt++;
      if (mem_ready) begin
        mem_ready = 1'b0;
        if (mem_valid) gap_err++;
      end else if (mem_valid) begin
        if (!pend) begin
          pend = 1;
          a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb;
          dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 7));
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wstrb !== s0) begin
          stab_err++;
        end
        if (dly == 0) begin
          pend = 0;
          mem_ready = 1'b1;
          if (s0 == 4'h0) begin
            mem_rdata = rd_model(a0);
            log_addr.push_back(a0); log_data.push_back(rd_model(a0)); log_we.push_back(1'b0);
          end else begin
            if (s0 != 4'hF) stab_err++;
            log_addr.push_back(a0); log_data.push_back(w0); log_we.push_back(1'b1);
          end
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic reg_wr(input logic [1:0] idx, input logic [31:0] d);
    bit acked = 0;
    ctrl_wr = 1'b1; ctrl_addr = {28'd0, idx, 2'b00}; ctrl_wdat = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ctrl_done) begin acked = 1; break; end
    end
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    if (!acked) check("wr_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic reg_rd(input logic [1:0] idx, output logic [31:0] d);
    bit acked = 0;
    d = '0;
    ctrl_rd = 1'b1; ctrl_addr = {28'd0, idx, 2'b00};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ctrl_done) begin acked = 1; d = ctrl_rdat; break; end
    end
    @(posedge clk); #1;
    ctrl_rd = 1'b0;
    if (!acked) check("rd_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      reg_rd(2'd3, r);
      if (!r[0]) begin ok = 1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r;
    int base;
    int v0;
    bit seen;
    ctrl_wr = 0; ctrl_rd = 0; ctrl_addr = '0; ctrl_wdat = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_low", 32'(mem_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reg_rd(2'd3, r); check("rst_ctrl", r, 32'h0);
    reg_rd(2'd0, r); check("rst_src", r, 32'h0);
    reg_rd(2'd1, r); check("rst_dst", r, 32'h0);
    reg_rd(2'd2, r); check("rst_len", r, 32'h0);

    // Basic 3-word copy, zero-latency slave
    fixed_dly = 0;
    base = log_addr.size();
    reg_wr(2'd0, 32'h100); reg_wr(2'd1, 32'h200); reg_wr(2'd2, 32'd3);
    reg_wr(2'd3, 32'h1);
    wait_idle("copy_idle");
    check("copy_ntx", 32'(log_addr.size() - base), 32'd6);
    if (log_addr.size() - base == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("copy_rd_addr", log_addr[base+2*i], 32'h100 + 32'(4*i));
        check("copy_rd_we", 32'(log_we[base+2*i]), 32'd0);
        check("copy_wr_addr", log_addr[base+2*i+1], 32'h200 + 32'(4*i));
        check("copy_wr_we", 32'(log_we[base+2*i+1]), 32'd1);
        check("copy_wr_data", log_data[base+2*i+1], rd_model(32'h100 + 32'(4*i)));
      end
    end
    reg_rd(2'd3, r); check("copy_ctrl", r, 32'h2);
    reg_rd(2'd2, r); check("copy_len", r, 32'h0);
    reg_rd(2'd0, r); check("copy_src", r, 32'h10C);
    reg_rd(2'd1, r); check("copy_dst", r, 32'h20C);

    // Random-stall slave, 4 words
    reg_wr(2'd3, 32'h8);
    reg_rd(2'd3, r); check("w1c_done", r, 32'h0);
    fixed_dly = -1;
    base = log_addr.size();
    reg_wr(2'd0, 32'h300); reg_wr(2'd1, 32'h400); reg_wr(2'd2, 32'd4);
    reg_wr(2'd3, 32'h1);
    wait_idle("stall_idle");
    check("stall_ntx", 32'(log_addr.size() - base), 32'd8);
    if (log_addr.size() - base == 8) begin
      for (int i = 0; i < 4; i++) begin
        check("stall_rd_addr", log_addr[base+2*i], 32'h300 + 32'(4*i));
        check("stall_wr_addr", log_addr[base+2*i+1], 32'h400 + 32'(4*i));
        check("stall_wr_data", log_data[base+2*i+1], rd_model(32'h300 + 32'(4*i)));
      end
    end
    check("stall_stable", 32'(stab_err), 32'd0);
    check("stall_gap", 32'(gap_err), 32'd0);
    reg_rd(2'd0, r); check("stall_src", r, 32'h310);

    // LEN=0 start with IE: immediate DONE, no bus traffic
    fixed_dly = 0;
    reg_wr(2'd3, 32'h8);
    reg_wr(2'd2, 32'd0);
    v0 = valid_cnt;
    reg_wr(2'd3, 32'h5);
    check("len0_irq", 32'(irq), 32'd1);
    reg_rd(2'd3, r); check("len0_ctrl", r, 32'h6);
    check("len0_no_bus", 32'(valid_cnt - v0), 32'd0);
    reg_wr(2'd3, 32'h8);
    check("len0_irq_clr", 32'(irq), 32'd0);
    reg_rd(2'd3, r); check("len0_done_clr", {31'd0, r[1]}, 32'd0);

    // ABORT during the read of word 2 of 5, slave latency 4
    fixed_dly = 4;
    base = log_addr.size();
    reg_wr(2'd0, 32'h500); reg_wr(2'd1, 32'h600); reg_wr(2'd2, 32'd5);
    reg_wr(2'd3, 32'h1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((log_addr.size() - base == 2) && mem_valid && mem_wstrb == 4'h0) begin seen = 1; break; end
    end
    check("abort_reach_rd2", 32'(seen), 32'd1);
    reg_wr(2'd3, 32'h2);
    wait_idle("abort_idle");
    repeat (10) @(posedge clk);
    #1;
    check("abort_ntx", 32'(log_addr.size() - base), 32'd3);
    if (log_addr.size() - base >= 3) begin
      check("abort_rd2_addr", log_addr[base+2], 32'h504);
      check("abort_rd2_we", 32'(log_we[base+2]), 32'd0);
    end
    reg_rd(2'd3, r); check("abort_ctrl", r, 32'h2);
    reg_rd(2'd2, r); check("abort_len", r, 32'd4);
    reg_rd(2'd0, r); check("abort_src", r, 32'h504);
    reg_rd(2'd1, r); check("abort_dst", r, 32'h604);

    // Misaligned writes and address wrap
    reg_wr(2'd3, 32'h8);
    reg_wr(2'd0, 32'h103);
    reg_rd(2'd0, r); check("align_src", r, 32'h100);
    reg_wr(2'd1, 32'h20B);
    reg_rd(2'd1, r); check("align_dst", r, 32'h208);
    fixed_dly = 1;
    base = log_addr.size();
    reg_wr(2'd0, 32'hFFFF_FFFC); reg_wr(2'd1, 32'h700); reg_wr(2'd2, 32'd2);
    reg_wr(2'd3, 32'h1);
    wait_idle("wrap_idle");
    check("wrap_ntx", 32'(log_addr.size() - base), 32'd4);
    if (log_addr.size() - base == 4) begin
      check("wrap_rd1_addr", log_addr[base], 32'hFFFF_FFFC);
      check("wrap_rd2_addr", log_addr[base+2], 32'h0000_0000);
      check("wrap_wr2_addr", log_addr[base+3], 32'h704);
      check("wrap_wr2_data", log_data[base+3], rd_model(32'h0));
    end
    reg_rd(2'd0, r); check("wrap_src", r, 32'h8 - 32'h4);
    check("final_stable", 32'(stab_err), 32'd0);
    check("final_gap", 32'(gap_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
